// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - Moore sequencing controller for the multicycle MIPS datapath
module mc_control_fsm #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_ADDI  = 6'b001000,
  parameter logic [5:0] OP_J     = 6'b000010
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       Branch,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic [1:0] aluop,
  output logic       illegal_op,
  output logic       instr_retire,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   legal_op;

  assign state = state_q;

  always_comb begin
    legal_op = 1'b0;
    case (Opcode)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: legal_op = 1'b1;
      default:                                       legal_op = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:   state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      // Opcode is held by the IR, so LW vs SW can be resolved again here
      S_MEMADR:  state_d = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWR:   state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXECUTE: state_d = S_ALUWB;
      S_ALUWB:   state_d = S_FETCH;
      S_BRANCH:  state_d = S_FETCH;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_ADDIWB:  state_d = S_FETCH;
      S_JUMP:    state_d = S_FETCH;
      default:   state_d = S_FETCH;
    endcase
  end

  always_comb begin
    PCWrite      = 1'b0;
    Branch       = 1'b0;
    IorD         = 1'b0;
    MemWrite     = 1'b0;
    IRWrite      = 1'b0;
    RegDst       = 1'b0;
    MemtoReg     = 1'b0;
    RegWrite     = 1'b0;
    ALUSrcA      = 1'b0;
    ALUSrcB      = 2'b00;
    PCSrc        = 2'b00;
    aluop        = 2'b00;
    illegal_op   = 1'b0;
    instr_retire = 1'b0;
    case (state_q)
      S_FETCH: begin
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: begin
        ALUSrcB    = 2'b11;
        illegal_op = ~legal_op;
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        IorD = 1'b1;
      end
      S_MEMWB: begin
        MemtoReg     = 1'b1;
        RegWrite     = 1'b1;
        instr_retire = 1'b1;
      end
      S_MEMWR: begin
        IorD         = 1'b1;
        MemWrite     = 1'b1;
        instr_retire = mem_ready;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        aluop   = 2'b10;
      end
      S_ALUWB: begin
        RegDst       = 1'b1;
        RegWrite     = 1'b1;
        instr_retire = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA      = 1'b1;
        aluop        = 2'b01;
        PCSrc        = 2'b01;
        Branch       = 1'b1;
        instr_retire = 1'b1;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_ADDIWB: begin
        RegWrite     = 1'b1;
        instr_retire = 1'b1;
      end
      S_JUMP: begin
        PCSrc        = 2'b10;
        PCWrite      = 1'b1;
        instr_retire = 1'b1;
      end
      default: begin
        PCWrite = 1'b0;
      end
    endcase
    // Architectural side effects are suppressed for the whole time reset is held
    if (!reset) begin
      PCWrite      = 1'b0;
      IRWrite      = 1'b0;
      MemWrite     = 1'b0;
      RegWrite     = 1'b0;
      Branch       = 1'b0;
      illegal_op   = 1'b0;
      instr_retire = 1'b0;
    end
  end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Sequencing controller for the multicycle variant of the MIPS core. Reuses the shared datapath (single ALU, unified instruction/data memory, IR, PC) across several cycles per instruction.
- A Moore FSM steps through fetch, decode, execute, memory and writeback. Opcode comes from the IR.
- Emits per-cycle mux selects, write enables and aluop. The existing ALU decoder turns aluop plus Funct into alucontrol.
- Memory access stalls on a ready handshake.

Parameters:
OP_RTYPE, 6'b000000, R-type opcode
OP_LW, 6'b100011, load word opcode
OP_SW, 6'b101011, store word opcode
OP_BEQ, 6'b000100, branch-equal opcode
OP_ADDI, 6'b001000, add-immediate opcode
OP_J, 6'b000010, jump opcode

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-low reset (0 = reset)
Opcode  input  6  IR[31:26]; valid from DECODE onward
mem_ready  input  1  memory completes the current read/write this cycle
PCWrite  output  1  unconditional PC write enable
Branch  output  1  conditional PC write (datapath ANDs with Zero)
IorD  output  1  memory address select: 0 = PC, 1 = ALUOut
MemWrite  output  1  memory write strobe
IRWrite  output  1  instruction register load
RegDst  output  1  write reg select: 0 = rt, 1 = rd
MemtoReg  output  1  writeback select: 0 = ALUOut, 1 = Data
RegWrite  output  1  register file write enable
ALUSrcA  output  1  0 = PC, 1 = A
ALUSrcB  output  2  00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
PCSrc  output  2  00 = ALUResult, 01 = ALUOut, 10 = jump target
aluop  output  2  00 add, 01 sub, 10 use Funct
illegal_op  output  1  unsupported opcode seen in DECODE
instr_retire  output  1  last cycle of an instruction
state  output  4  current state encoding (debug/verification)

Behaviour:
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Codes 12-15 are unused and go to FETCH on the next edge.
- Reset: on a rising edge with reset=0, state goes to FETCH. While reset=0, PCWrite, IRWrite, MemWrite, RegWrite, Branch, illegal_op and instr_retire are forced to 0.
- Reset mid-instruction abandons the instruction. There is no partial writeback after reset is released.
- Outputs are combinational from state, gated by mem_ready where noted. Any output not listed for a state is 0.
- FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, aluop=00, PCSrc=00.
  - IRWrite=PCWrite=mem_ready.
  - Go to DECODE when mem_ready=1, otherwise stay.
- DECODE: ALUSrcA=0, ALUSrcB=11, aluop=00.
  - Next state by Opcode: LW/SW to MEMADR, RTYPE to EXECUTE, BEQ to BRANCH, ADDI to ADDIEX, J to JUMP.
  - Any other opcode: illegal_op=1 for this cycle and next state is FETCH. The PC has already advanced, so the instruction acts as a NOP.
- MEMADR: ALUSrcA=1, ALUSrcB=10, aluop=00. Next state is MEMRD for LW, MEMWR for SW (Opcode held stable by the IR).
- MEMRD: IorD=1. Go to MEMWB when mem_ready=1, otherwise stay.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1, instr_retire=1. Next state FETCH.
- MEMWR: IorD=1, MemWrite=1, held for every cycle of the wait.
  - When mem_ready=1: instr_retire=1 and next state FETCH. Otherwise stay.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, aluop=10. Next state ALUWB.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1, instr_retire=1. Next state FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, aluop=01, PCSrc=01, Branch=1, instr_retire=1. Next state FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, aluop=00. Next state ADDIWB.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1, instr_retire=1. Next state FETCH.
- JUMP: PCSrc=10, PCWrite=1, instr_retire=1. Next state FETCH.
- Latency with zero-wait memory (mem_ready tied 1): LW 5, SW 4, R-type 4, ADDI 4, BEQ 3, J 3 cycles.
- Each cycle of mem_ready=0 in FETCH, MEMRD or MEMWR adds exactly one cycle.
- Exactly one instr_retire pulse per legal instruction; none for an illegal one.
- mem_ready is ignored in all states other than FETCH, MEMRD and MEMWR.

Test Plan:
- Reset: hold reset=0 for 3 cycles with mem_ready=1 -> state=0 and PCWrite=IRWrite=RegWrite=MemWrite=0 throughout. First cycle after release: PCWrite=1, IRWrite=1.
- mem_ready=1, Opcode=100011 (LW) -> state sequence 0,1,2,3,4,0. RegWrite=1, MemtoReg=1 only in state 4. instr_retire once.
- SW with mem_ready low for 2 cycles in MEMWR -> states 0,1,2,5,5,5,0. MemWrite=1 on all three MEMWR cycles. instr_retire only on the third.
- R-type then BEQ then J back-to-back, mem_ready=1 -> 4+3+3 = 10 cycles. aluop=10 in EXECUTE, 01 in BRANCH. PCSrc=10 with PCWrite=1 in JUMP.
- FETCH with mem_ready=0 for 4 cycles -> state stays 0 and IRWrite=PCWrite=0 for those cycles. Advances on the first mem_ready=1 cycle.
- Opcode=111111 in DECODE -> illegal_op=1 for one cycle, next state 0, no RegWrite/MemWrite/instr_retire. Separately, reset=0 asserted in MEMWB -> RegWrite=0 that cycle, state=0 next.
